// File: rtl/fpcvt_pkg.sv
// Shared types and constants for the 12-bit linear to 8-bit float conversion path.
package fpcvt_pkg;

    localparam int         LIN_W      = 12;
    localparam int         FP_W       = 8;
    localparam logic [6:0] FP_SAT_MAG = 7'h7F;

    typedef struct packed {
        logic       sign;
        logic [2:0] exp;
        logic [3:0] sig;
    } fp8_t;

endpackage

// File: rtl/fpcvt_conv.sv
// Combinational 12-bit two's complement to fp8 converter (sign, 3-bit exponent, 4-bit significand).
module fpcvt_conv
    import fpcvt_pkg::*;
(
    input  logic [LIN_W-1:0] lin_in,
    output fp8_t             fp_out
);

    logic [10:0] mag;
    logic [3:0]  msb;
    logic [4:0]  window;
    logic [4:0]  rnd_sig;
    logic [3:0]  exp_w;

    // Values below 16 pass through unscaled; larger ones keep 4 bits from the leading one and round on the fifth.
    always_comb begin
        fp_out  = '0;
        window  = '0;
        rnd_sig = '0;
        exp_w   = '0;
        msb     = '0;

        if (lin_in == 12'h800) begin
            mag = 11'h7FF;
        end else if (lin_in[11]) begin
            mag = 11'(~lin_in + 12'd1);
        end else begin
            mag = lin_in[10:0];
        end

        for (int i = 0; i < 11; i++) begin
            if (mag[i]) begin
                msb = 4'(i);
            end
        end

        fp_out.sign = lin_in[11];
        if (msb < 4'd4) begin
            fp_out.exp = 3'd0;
            fp_out.sig = mag[3:0];
        end else begin
            window  = 5'(mag >> (msb - 4'd4));
            rnd_sig = {1'b0, window[4:1]} + {4'b0000, window[0]};
            exp_w   = msb - 4'd3;
            if (rnd_sig[4]) begin
                rnd_sig = 5'd8;
                exp_w   = exp_w + 4'd1;
            end
            if (exp_w > 4'd7) begin
                fp_out.exp = 3'd7;
                fp_out.sig = 4'hF;
            end else begin
                fp_out.exp = exp_w[2:0];
                fp_out.sig = rnd_sig[3:0];
            end
        end
    end

endmodule

// File: rtl/fpcvt_sched.sv
// Round-robin scheduler sharing one fp8 converter among NUM_REQ requesters,
// with a small output FIFO and a saturation event counter.
module fpcvt_sched
    import fpcvt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LIN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FP_W-1:0]          out_data,
    output logic [ID_W-1:0]          out_id,
    input  logic                     sat_clr,
    output logic [15:0]              sat_cnt,
    output logic                     busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  last_q, last_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      sat_q, sat_d;
    fp8_t             data_mem_q [DEPTH];
    fp8_t             data_mem_d [DEPTH];
    logic [ID_W-1:0]  id_mem_q [DEPTH];
    logic [ID_W-1:0]  id_mem_d [DEPTH];

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  scan_idx;
    logic             space;
    logic             push;
    logic             pop;
    logic [LIN_W-1:0] sel_data;
    fp8_t             conv_out;

    // Scan starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Space uses the pre-pop count, so a full FIFO never grants even while popping.
    assign space = count_q < CNT_W'(DEPTH);
    assign push  = grant_found && space && !rst;
    assign pop   = out_valid && out_ready;

    always_comb begin
        req_ready = '0;
        if (push) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_data = req_data[int'(grant_idx)*LIN_W +: LIN_W];

    fpcvt_conv u_conv (
        .lin_in (sel_data),
        .fp_out (conv_out)
    );

    always_comb begin
        last_d   = last_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        count_d  = count_q;
        sat_d    = sat_q;
        data_mem_d = data_mem_q;
        id_mem_d   = id_mem_q;

        if (push) begin
            data_mem_d[wr_q] = conv_out;
            id_mem_d[wr_q]   = grant_idx;
            wr_d             = wr_q + 1'b1;
            last_d           = grant_idx;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        if (sat_clr) begin
            sat_d = '0;
        end else if (push && {conv_out.exp, conv_out.sig} == FP_SAT_MAG && sat_q != 16'hFFFF) begin
            sat_d = sat_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= ID_W'(NUM_REQ - 1);
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            sat_q      <= '0;
            data_mem_q <= '{default: '0};
            id_mem_q   <= '{default: '0};
        end else begin
            last_q     <= last_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
            data_mem_q <= data_mem_d;
            id_mem_q   <= id_mem_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = data_mem_q[rd_q];
    assign out_id    = id_mem_q[rd_q];
    assign sat_cnt   = sat_q;
    assign busy      = out_valid || (|req_valid);

endmodule

// File: tb/tb_fpcvt_sched.sv
// Scoreboard bench for fpcvt_sched: directed stimulus queues expected outputs, a monitor checks pops.
module tb_fpcvt_sched;
    import fpcvt_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DEPTH   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*LIN_W-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [FP_W-1:0]          out_data;
    logic [ID_W-1:0]          out_id;
    logic                     sat_clr;
    logic [15:0]              sat_cnt;
    logic                     busy;

    int checks   = 0;
    int failures = 0;
    logic [9:0] exp_q [$];

    fpcvt_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pack4(input logic [11:0] d0, input logic [11:0] d1,
                                          input logic [11:0] d2, input logic [11:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic void expectPush(input logic [7:0] data, input logic [1:0] id);
        exp_q.push_back({id, data});
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Inputs change on the falling edge; the caller samples 4 time units later, before the next rising edge.
    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [47:0] d,
                                 input logic ordy, input logic clr);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        sat_clr   = clr;
        #4;
    endtask

    initial begin : monitor
        logic [9:0] head;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_pop: got data=%0h id=%0d required no output", out_data, out_id);
                end else begin
                    head = exp_q.pop_front();
                    checkOutput("pop_data", 32'(out_data), 32'(head[7:0]));
                    checkOutput("pop_id", 32'(out_id), 32'(head[9:8]));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [47:0] d;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;

        // Reset state, with a requester already valid
        applyStimulus(1'b1, 4'b0001, pack4(12'h1A6, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0);
        applyStimulus(1'b1, 4'b0001, pack4(12'h1A6, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_data", 32'(out_data), 32'h0);
        checkOutput("rst_out_id", 32'(out_id), 32'h0);
        checkOutput("rst_sat_cnt", 32'(sat_cnt), 32'h0);

        // Single sample latency
        applyStimulus(1'b0, 4'b0001, pack4(12'h1A6, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0);
        checkOutput("t1_req_ready", 32'(req_ready), 32'h1);
        expectPush(8'h5D, 2'd0);
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);
        checkOutput("t1_out_valid", 32'(out_valid), 32'h1);
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);

        // All four requesters, full throughput
        applyStimulus(1'b1, 4'b0000, '0, 1'b1, 1'b0);
        d = pack4(12'h000, 12'h005, 12'hFFF, 12'h7FF);
        applyStimulus(1'b0, 4'b1111, d, 1'b1, 1'b0);
        checkOutput("t2_grant0", 32'(req_ready), 32'h1);
        expectPush(8'h00, 2'd0);
        applyStimulus(1'b0, 4'b1110, d, 1'b1, 1'b0);
        checkOutput("t2_grant1", 32'(req_ready), 32'h2);
        expectPush(8'h05, 2'd1);
        applyStimulus(1'b0, 4'b1100, d, 1'b1, 1'b0);
        checkOutput("t2_grant2", 32'(req_ready), 32'h4);
        expectPush(8'h81, 2'd2);
        applyStimulus(1'b0, 4'b1000, d, 1'b1, 1'b0);
        checkOutput("t2_grant3", 32'(req_ready), 32'h8);
        expectPush(8'h7F, 2'd3);
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);
        checkOutput("t2_sat_cnt", 32'(sat_cnt), 32'h1);
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);
        checkOutput("t2_drained", 32'(out_valid), 32'h0);

        // Backpressure: fill, hold, then resume
        applyStimulus(1'b0, 4'b0001, pack4(12'h010, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0);
        checkOutput("t3_push0", 32'(req_ready), 32'h1);
        expectPush(8'h18, 2'd0);
        applyStimulus(1'b0, 4'b0001, pack4(12'h003, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0);
        checkOutput("t3_push1", 32'(req_ready), 32'h1);
        checkOutput("t3_head_a", 32'(out_data), 32'h18);
        expectPush(8'h03, 2'd0);
        applyStimulus(1'b0, 4'b0001, pack4(12'h020, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0);
        checkOutput("t3_full_ready", 32'(req_ready), 32'h0);
        checkOutput("t3_head_b", 32'(out_data), 32'h18);
        checkOutput("t3_head_id", 32'(out_id), 32'h0);
        checkOutput("t3_busy", 32'(busy), 32'h1);
        applyStimulus(1'b0, 4'b0001, pack4(12'h020, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0);
        checkOutput("t3_full_ready2", 32'(req_ready), 32'h0);
        checkOutput("t3_head_c", 32'(out_data), 32'h18);
        applyStimulus(1'b0, 4'b0001, pack4(12'h020, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0);
        checkOutput("t3_pop_no_push", 32'(req_ready), 32'h0);
        applyStimulus(1'b0, 4'b0001, pack4(12'h020, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0);
        checkOutput("t3_resume", 32'(req_ready), 32'h1);
        expectPush(8'h28, 2'd0);
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);
        checkOutput("t3_drained", 32'(out_valid), 32'h0);

        // Saturation and counter clear
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'b0001, pack4(12'h800, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0);
        checkOutput("t4_sat_cleared", 32'(sat_cnt), 32'h0);
        checkOutput("t4_grant_a", 32'(req_ready), 32'h1);
        expectPush(8'hFF, 2'd0);
        applyStimulus(1'b0, 4'b0001, pack4(12'h7F0, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0);
        checkOutput("t4_grant_b", 32'(req_ready), 32'h1);
        expectPush(8'h7F, 2'd0);
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);
        checkOutput("t4_sat_two", 32'(sat_cnt), 32'h2);
        applyStimulus(1'b0, 4'b0001, pack4(12'h800, 12'h0, 12'h0, 12'h0), 1'b1, 1'b1);
        checkOutput("t4_grant_c", 32'(req_ready), 32'h1);
        expectPush(8'hFF, 2'd0);
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);
        checkOutput("t4_clr_priority", 32'(sat_cnt), 32'h0);
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);

        // Fairness between requesters 1 and 3
        d = pack4(12'h000, 12'h001, 12'h000, 12'h002);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4'b1010, d, 1'b1, 1'b0);
            if (i % 2 == 0) begin
                checkOutput("t5_grant_r1", 32'(req_ready), 32'h2);
                expectPush(8'h01, 2'd1);
            end else begin
                checkOutput("t5_grant_r3", 32'(req_ready), 32'h8);
                expectPush(8'h02, 2'd3);
            end
        end
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);

        // Reset with two entries queued discards them
        applyStimulus(1'b0, 4'b0001, pack4(12'h004, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0001, pack4(12'h004, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0);
        d = pack4(12'h006, 12'h007, 12'h008, 12'h000);
        applyStimulus(1'b1, 4'b0111, d, 1'b0, 1'b0);
        checkOutput("t6_rst_ready", 32'(req_ready), 32'h0);
        checkOutput("t6_queued_head", 32'(out_data), 32'h04);
        applyStimulus(1'b0, 4'b0111, d, 1'b1, 1'b0);
        checkOutput("t6_flushed", 32'(out_valid), 32'h0);
        checkOutput("t6_grant0", 32'(req_ready), 32'h1);
        expectPush(8'h06, 2'd0);
        applyStimulus(1'b0, 4'b0110, d, 1'b1, 1'b0);
        checkOutput("t6_grant1", 32'(req_ready), 32'h2);
        expectPush(8'h07, 2'd1);
        applyStimulus(1'b0, 4'b0100, d, 1'b1, 1'b0);
        checkOutput("t6_grant2", 32'(req_ready), 32'h4);
        expectPush(8'h08, 2'd2);
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0);
        checkOutput("end_busy", 32'(busy), 32'h0);
        checkOutput("end_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
